// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: pixel divider, column/row
// counters, combinational sync/blank decode, line/frame strobes, frame
// counter and a fixed-depth delayed copy of sync/blank for pin alignment.
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 29,
    parameter int CLK_DIV  = 2,
    parameter int HS_POL   = 0,
    parameter int VS_POL   = 0,
    parameter int PIPE     = 2,
    parameter int FC_W     = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    output logic [10:0]     col,
    output logic [9:0]      row,
    output logic            pix_en,
    output logic            hs,
    output logic            vs,
    output logic            blank,
    output logic            hs_d,
    output logic            vs_d,
    output logic            blank_d,
    output logic            line_start,
    output logic            frame_start,
    output logic [FC_W-1:0] frame_count
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [10:0]      COL_LAST = 11'(H_TOTAL - 1);
    localparam logic [9:0]       ROW_LAST = 10'(V_TOTAL - 1);

    // Decode bounds are held one bit wider so an end bound equal to the
    // total (zero back porch at maximum size) cannot overflow.
    localparam logic [11:0] H_ACT_END = 12'(H_ACTIVE);
    localparam logic [11:0] HS_START  = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0] HS_END    = 12'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] V_ACT_END = 11'(V_ACTIVE);
    localparam logic [10:0] VS_START  = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_END    = 11'(V_ACTIVE + V_FP + V_SYNC);

    localparam logic       HS_ACT  = (HS_POL != 0) ? 1'b1 : 1'b0;
    localparam logic       VS_ACT  = (VS_POL != 0) ? 1'b1 : 1'b0;
    localparam logic [2:0] RST_DEC = {~HS_ACT, ~VS_ACT, 1'b0};

    if (H_TOTAL > 2048) begin : g_chk_h
        $error("vga_timing_gen: H_TOTAL does not fit the 11-bit column counter");
    end
    if (V_TOTAL > 1024) begin : g_chk_v
        $error("vga_timing_gen: V_TOTAL does not fit the 10-bit row counter");
    end
    if (CLK_DIV < 1) begin : g_chk_div
        $error("vga_timing_gen: CLK_DIV must be at least 1");
    end
    if (PIPE < 0) begin : g_chk_pipe
        $error("vga_timing_gen: PIPE must not be negative");
    end

    logic [DIV_W-1:0] div_cnt;
    logic             div_last;
    logic             col_last;
    logic             row_last;

    assign div_last = (div_cnt == DIV_LAST);
    assign pix_en   = en & div_last;
    assign col_last = (col == COL_LAST);
    assign row_last = (row == ROW_LAST);

    // Clock divider: free-runs 0..CLK_DIV-1 while enabled, holds otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
        end else if (en) begin
            if (div_last) begin
                div_cnt <= '0;
            end else begin
                div_cnt <= div_cnt + DIV_W'(1);
            end
        end
    end

    // Raster position: advance one pixel per tick, wrapping line and frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col <= 11'd0;
            row <= 10'd0;
        end else if (pix_en) begin
            if (col_last) begin
                col <= 11'd0;
                if (row_last) begin
                    row <= 10'd0;
                end else begin
                    row <= row + 10'd1;
                end
            end else begin
                col <= col + 11'd1;
            end
        end
    end

    // Start strobes and completed-frame count, registered on the wrap edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            frame_count <= '0;
        end else begin
            line_start  <= pix_en & col_last;
            frame_start <= pix_en & col_last & row_last;
            if (pix_en && col_last && row_last) begin
                frame_count <= frame_count + FC_W'(1);
            end
        end
    end

    // Zero-latency sync/blank decode from the current raster position.
    always_comb begin
        hs    = ~HS_ACT;
        vs    = ~VS_ACT;
        blank = 1'b0;
        if (({1'b0, col} >= HS_START) && ({1'b0, col} < HS_END)) begin
            hs = HS_ACT;
        end else begin
            hs = ~HS_ACT;
        end
        if (({1'b0, row} >= VS_START) && ({1'b0, row} < VS_END)) begin
            vs = VS_ACT;
        end else begin
            vs = ~VS_ACT;
        end
        if (({1'b0, col} >= H_ACT_END) || ({1'b0, row} >= V_ACT_END)) begin
            blank = 1'b1;
        end else begin
            blank = 1'b0;
        end
    end

    // Delayed sync/blank copy; runs every clk so it drains while paused.
    if (PIPE == 0) begin : g_nodly
        assign hs_d    = hs;
        assign vs_d    = vs;
        assign blank_d = blank;
    end else begin : g_dly
        logic [2:0] dly [PIPE];

        // Shift the decoded triple one stage per clk.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int k = 0; k < PIPE; k++) begin
                    dly[k] <= RST_DEC;
                end
            end else begin
                dly[0] <= {hs, vs, blank};
                for (int k = 1; k < PIPE; k++) begin
                    dly[k] <= dly[k-1];
                end
            end
        end

        assign {hs_d, vs_d, blank_d} = dly[PIPE-1];
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen: two small-raster instances
// (8 x 6 totals) with different divider, polarity, pipe depth and
// frame-counter width, driven by random enable plus a long pause and a
// mid-frame asynchronous reset. Expectations come from a pixel-count model.
module tb_vga_timing_gen;

    typedef struct packed {
        logic [10:0] col;
        logic [9:0]  row;
        logic        pix_en;
        logic        hs;
        logic        vs;
        logic        blank;
        logic        hs_d;
        logic        vs_d;
        logic        blank_d;
        logic        ls;
        logic        fs;
        logic [15:0] fc;
    } obs_t;

    typedef struct packed {
        obs_t i1;
        obs_t i0;
    } pair_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic en    = 1'b1;

    always #5 clk = ~clk;

    logic [10:0] col_a, col_b;
    logic [9:0]  row_a, row_b;
    logic pe_a, hs_a, vs_a, bl_a, hsd_a, vsd_a, bld_a, ls_a, fs_a;
    logic pe_b, hs_b, vs_b, bl_b, hsd_b, vsd_b, bld_b, ls_b, fs_b;
    logic [1:0] fc_a;
    logic [2:0] fc_b;

    vga_timing_gen #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .CLK_DIV(2), .HS_POL(0), .VS_POL(0), .PIPE(2), .FC_W(2)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .en(en),
        .col(col_a), .row(row_a), .pix_en(pe_a),
        .hs(hs_a), .vs(vs_a), .blank(bl_a),
        .hs_d(hsd_a), .vs_d(vsd_a), .blank_d(bld_a),
        .line_start(ls_a), .frame_start(fs_a), .frame_count(fc_a)
    );

    vga_timing_gen #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .CLK_DIV(1), .HS_POL(1), .VS_POL(1), .PIPE(0), .FC_W(3)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .en(en),
        .col(col_b), .row(row_b), .pix_en(pe_b),
        .hs(hs_b), .vs(vs_b), .blank(bl_b),
        .hs_d(hsd_b), .vs_d(vsd_b), .blank_d(bld_b),
        .line_start(ls_b), .frame_start(fs_b), .frame_count(fc_b)
    );

    obs_t got_a, got_b;
    assign got_a = {col_a, row_a, pe_a, hs_a, vs_a, bl_a, hsd_a, vsd_a, bld_a,
                    ls_a, fs_a, {14'd0, fc_a}};
    assign got_b = {col_b, row_b, pe_b, hs_b, vs_b, bl_b, hsd_b, vsd_b, bld_b,
                    ls_b, fs_b, {13'd0, fc_b}};

    pair_t exp_q[$];
    int total = 0;
    int bad   = 0;

    // Per-instance configuration of the two DUTs above.
    function automatic int c_div(input int i);
        return (i == 0) ? 2 : 1;
    endfunction
    function automatic int c_pipe(input int i);
        return (i == 0) ? 2 : 0;
    endfunction
    function automatic int c_fcw(input int i);
        return (i == 0) ? 2 : 3;
    endfunction
    function automatic logic c_pol(input int i);
        return (i == 0) ? 1'b0 : 1'b1;
    endfunction

    // Expected outputs given e enabled clocks since reset: the raster is
    // simply pixel number p = e / div laid out on an 8 x 6 grid.
    function automatic obs_t model(input int i, input int e, input logic en_v,
                                   input logic ls, input logic fs,
                                   input logic [2:0] dly);
        obs_t o;
        int   div = c_div(i);
        int   p   = e / div;
        int   c   = p % 8;
        int   r   = (p / 8) % 6;
        logic pol = c_pol(i);
        o.col    = 11'(c);
        o.row    = 10'(r);
        o.pix_en = en_v && ((e % div) == (div - 1));
        o.hs     = (c >= 5 && c < 7) ? pol : ~pol;
        o.vs     = (r == 4) ? pol : ~pol;
        o.blank  = (c >= 4) || (r >= 3);
        if (c_pipe(i) == 0) begin
            {o.hs_d, o.vs_d, o.blank_d} = {o.hs, o.vs, o.blank};
        end else begin
            {o.hs_d, o.vs_d, o.blank_d} = dly;
        end
        o.ls = ls;
        o.fs = fs;
        o.fc = 16'((p / 48) % (1 << c_fcw(i)));
        return o;
    endfunction

    task automatic chk(input string nm, input int i, input logic [31:0] g,
                       input logic [31:0] w);
        total++;
        if (g !== w) begin
            bad++;
            $display("FAIL %s[%0d] t=%0t got=%0d want=%0d", nm, i, $time, g, w);
        end
    endtask

    task automatic check_obs(input int i, input obs_t g, input obs_t w);
        chk("col", i, 32'(g.col), 32'(w.col));
        chk("row", i, 32'(g.row), 32'(w.row));
        chk("pix_en", i, 32'(g.pix_en), 32'(w.pix_en));
        chk("hs", i, 32'(g.hs), 32'(w.hs));
        chk("vs", i, 32'(g.vs), 32'(w.vs));
        chk("blank", i, 32'(g.blank), 32'(w.blank));
        chk("hs_d", i, 32'(g.hs_d), 32'(w.hs_d));
        chk("vs_d", i, 32'(g.vs_d), 32'(w.vs_d));
        chk("blank_d", i, 32'(g.blank_d), 32'(w.blank_d));
        chk("line_start", i, 32'(g.ls), 32'(w.ls));
        chk("frame_start", i, 32'(g.fs), 32'(w.fs));
        chk("frame_count", i, 32'(g.fc), 32'(w.fc));
    endtask

    // Monitor: on every falling edge compare the DUTs with the oldest expectation.
    always @(negedge clk) begin
        pair_t p;
        if (exp_q.size() > 0) begin
            p = exp_q.pop_front();
            check_obs(0, got_a, p.i0);
            check_obs(1, got_b, p.i1);
        end
    end

    // Stimulus and reference model: step the model for the edge just taken,
    // choose new inputs, then queue what the DUTs must show this cycle.
    initial begin
        int         e_cnt [2];
        logic       prev_pe [2];
        logic       ls_m [2];
        logic       fs_m [2];
        logic [2:0] cur_dec [2];
        logic [2:0] hist [2][4];
        int         hold_left = 0;
        bit         hold_done = 1'b0;
        pair_t      pr;
        obs_t       o;
        int         p;

        rst_n = 1'b0;
        en    = 1'b1;
        for (int i = 0; i < 2; i++) begin
            e_cnt[i] = 0; prev_pe[i] = 1'b0; ls_m[i] = 1'b0; fs_m[i] = 1'b0;
            cur_dec[i] = {~c_pol(i), ~c_pol(i), 1'b0};
            for (int k = 0; k < 4; k++) hist[i][k] = {~c_pol(i), ~c_pol(i), 1'b0};
        end

        for (int n = 0; n < 3000; n++) begin
            @(posedge clk);
            #1;
            for (int i = 0; i < 2; i++) begin
                if (rst_n) begin
                    if (en) e_cnt[i]++;
                    if (prev_pe[i]) begin
                        p = e_cnt[i] / c_div(i);
                        ls_m[i] = ((p % 8) == 0);
                        fs_m[i] = ((p % 48) == 0);
                    end else begin
                        ls_m[i] = 1'b0;
                        fs_m[i] = 1'b0;
                    end
                    for (int k = 3; k > 0; k--) hist[i][k] = hist[i][k-1];
                    hist[i][0] = cur_dec[i];
                end else begin
                    e_cnt[i] = 0; ls_m[i] = 1'b0; fs_m[i] = 1'b0;
                end
            end

            rst_n = !(n < 3 || (n >= 1800 && n < 1803));
            if (rst_n && !hold_done && n > 300 && ((e_cnt[0] / 2) % 8) == 5) begin
                hold_left = 37;
                hold_done = 1'b1;
            end
            if (hold_left > 0) begin
                en = 1'b0;
                hold_left--;
            end else begin
                en = ($urandom_range(0, 9) != 0);
            end

            if (!rst_n) begin
                for (int i = 0; i < 2; i++) begin
                    e_cnt[i] = 0; ls_m[i] = 1'b0; fs_m[i] = 1'b0;
                    for (int k = 0; k < 4; k++) hist[i][k] = {~c_pol(i), ~c_pol(i), 1'b0};
                end
            end

            for (int i = 0; i < 2; i++) begin
                o = model(i, e_cnt[i], en, ls_m[i], fs_m[i],
                          hist[i][(c_pipe(i) > 0) ? c_pipe(i) - 1 : 0]);
                prev_pe[i] = o.pix_en;
                cur_dec[i] = {o.hs, o.vs, o.blank};
                if (i == 0) pr.i0 = o;
                else        pr.i1 = o;
            end
            exp_q.push_back(pr);
        end

        @(negedge clk);
        #1;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain left=%0d want=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
